// File: rtl/loader_pkg.sv
// Shared types and widths for the instruction-memory loader.
// Optional checksum trailer is enabled by defining LOADER_CHECKSUM_EN.
package loader_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned INSN_W = 9;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    WORD_LO,
    WORD_HI,
    CSUM,
    DONE,
    ERR
  } state_e;

endpackage

// File: rtl/loader_word_pack.sv
// Word packer: latches the low byte of an instruction, validates the high byte
// and presents the assembled 9-bit word in the same cycle the high byte arrives.
module loader_word_pack
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [BYTE_W-1:0] byte_i,
  input  logic              lo_load_i,
  input  logic              hi_load_i,
  output logic [INSN_W-1:0] word_o,
  output logic              valid_o,
  output logic              fmt_err_o
);

  logic [BYTE_W-1:0] lo_q;
  logic              hi_bad;

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          lo_q <= '0;
    else if (lo_load_i) lo_q <= byte_i;
  end

  assign hi_bad    = |byte_i[BYTE_W-1:1];
  assign fmt_err_o = hi_load_i & hi_bad;
  assign valid_o   = hi_load_i & ~hi_bad;
  assign word_o    = {byte_i[0], lo_q};

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: parses a length-prefixed byte stream, writes 9-bit
// words at ascending addresses and holds the core while loading (LOADER_CHECKSUM_EN adds an XOR trailer).
module imem_loader
  import loader_pkg::*;
#(
  parameter int unsigned D = 10,
  parameter int unsigned W = INSN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [D-1:0]      wr_addr,
  output logic [W-1:0]      wr_data,
  output logic              core_hold,
  output logic              load_done,
  output logic              load_err
);

  localparam int unsigned HI_W = D - BYTE_W;

`ifdef LOADER_CHECKSUM_EN
  localparam state_e END_S = CSUM;
`else
  localparam state_e END_S = DONE;
`endif

  state_e            state_q, state_d;
  logic [D-1:0]      len_q, len_d;
  logic [D-1:0]      wr_addr_q, wr_addr_d;
  logic              wr_en_q;
  logic [W-1:0]      wr_data_q;
  logic              xfer, can_start, last_wr, hi_overflow;
  logic              lo_load, hi_load, pack_valid, pack_err;
  logic [INSN_W-1:0] pack_word;
  logic [D-1:0]      hdr_len;

  assign can_start   = (state_q == IDLE) || (state_q == DONE) || (state_q == ERR);
  assign xfer        = in_valid & in_ready;
  assign hdr_len     = {in_data[HI_W-1:0], len_q[BYTE_W-1:0]};
  assign hi_overflow = |in_data[BYTE_W-1:HI_W];
  // The final write is in flight: stall the stream until the session closes.
  assign last_wr     = wr_en_q && ((wr_addr_q + D'(1)) == len_q);

  loader_word_pack u_pack (
    .clk      (clk),
    .reset    (reset),
    .byte_i   (in_data),
    .lo_load_i(lo_load),
    .hi_load_i(hi_load),
    .word_o   (pack_word),
    .valid_o  (pack_valid),
    .fmt_err_o(pack_err)
  );

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    in_ready = 1'b0;
    unique case (state_q)
      LEN_LO, LEN_HI, WORD_HI, CSUM: in_ready = 1'b1;
      WORD_LO:                       in_ready = !last_wr;
      default:                       in_ready = 1'b0;
    endcase
  end

`ifdef LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] csum_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                        csum_q <= '0;
    else if (can_start && start)      csum_q <= '0;
    else if (xfer && state_q != CSUM) csum_q <= csum_q ^ in_data;
  end
`endif

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    wr_addr_d = wr_addr_q;
    lo_load   = 1'b0;
    hi_load   = 1'b0;
    if (wr_en_q) wr_addr_d = wr_addr_q + D'(1);

    unique case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d   = LEN_LO;
          wr_addr_d = '0;
        end
      end
      LEN_LO: begin
        if (xfer) begin
          len_d[BYTE_W-1:0] = in_data;
          state_d           = LEN_HI;
        end
      end
      LEN_HI: begin
        if (xfer) begin
          if (hi_overflow) begin
            state_d = ERR;
          end else begin
            len_d   = hdr_len;
            state_d = (hdr_len == '0) ? END_S : WORD_LO;
          end
        end
      end
      WORD_LO: begin
        if (last_wr) begin
          state_d = END_S;
        end else if (xfer) begin
          lo_load = 1'b1;
          state_d = WORD_HI;
        end
      end
      WORD_HI: begin
        if (xfer) begin
          hi_load = 1'b1;
          state_d = pack_err ? ERR : WORD_LO;
        end
      end
      CSUM: begin
`ifdef LOADER_CHECKSUM_EN
        if (xfer) state_d = (in_data == csum_q) ? DONE : ERR;
`else
        state_d = IDLE;
`endif
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      len_q     <= '0;
      wr_addr_q <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      wr_addr_q <= wr_addr_d;
      wr_en_q   <= pack_valid;
      if (pack_valid) wr_data_q <= W'(pack_word);
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign core_hold = !((state_q == IDLE) || (state_q == DONE));
  assign load_done = (state_q == DONE);
  assign load_err  = (state_q == ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: a stream-level reference model queues the
// expected writes, an independent monitor pops and compares them on every wr_en.
module tb_imem_loader;

  localparam int D = 10;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready, wr_en, core_hold, load_done, load_err;
  logic [D-1:0] wr_addr;
  logic [8:0] wr_data;

  int n_vec = 0;
  int n_err = 0;

  wr_t        exp_q[$];
  logic [7:0] stim[$];
  bit         m_err;
  int         m_nsend;
  int         m_nwr;

  imem_loader #(.D(D), .W(9)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .core_hold(core_hold),
    .load_done(load_done),
    .load_err (load_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (!reset && wr_en === 1'b1) begin
      check("write_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        wr_t w;
        w = exp_q.pop_front();
        check("wr_addr", 32'(wr_addr), w.addr);
        check("wr_data", 32'(wr_data), w.data);
      end
    end
  end

  function automatic logic [7:0] xor_all();
    logic [7:0] x = 8'h00;
    foreach (stim[i]) x ^= stim[i];
    return x;
  endfunction

  // Reference model: interpret the stream by its format rules.
  task automatic model_stream();
    int hdr, p;
    logic [7:0] x;
    m_err = 1'b0;
    m_nwr = 0;
    hdr   = int'(stim[0]) + 256 * int'(stim[1]);
    x     = stim[0] ^ stim[1];
    p     = 2;
    if (hdr >= (1 << D)) begin
      m_err   = 1'b1;
      m_nsend = 2;
      return;
    end
    for (int i = 0; i < hdr; i++) begin
      int lo, hi;
      wr_t w;
      lo = int'(stim[p]);
      hi = int'(stim[p+1]);
      p += 2;
      if (hi > 1) begin
        m_err   = 1'b1;
        m_nsend = p;
        return;
      end
      x ^= stim[p-2] ^ stim[p-1];
      w.addr = i;
      w.data = hi * 256 + lo;
      exp_q.push_back(w);
      m_nwr++;
    end
`ifdef LOADER_CHECKSUM_EN
    if (stim[p] != x) m_err = 1'b1;
    p++;
`endif
    m_nsend = p;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_max);
    int budget = 50;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    check("in_ready_accept", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    repeat ($urandom_range(0, gap_max)) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic run_session(input int gap_max);
    int budget = 40;
    start_pulse();
    check("hold_after_start", 32'(core_hold), 32'd1);
    check("done_cleared", 32'(load_done), 32'd0);
    check("err_cleared", 32'(load_err), 32'd0);
    model_stream();
    for (int i = 0; i < m_nsend; i++) send_byte(stim[i], gap_max);
    while (!(load_done || load_err) && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    check("load_done", 32'(load_done), 32'(!m_err));
    check("load_err", 32'(load_err), 32'(m_err));
    check("core_hold_end", 32'(core_hold), 32'(m_err));
    check("in_ready_end", 32'(in_ready), 32'd0);
    check("words_written", 32'(wr_addr), 32'(m_nwr));
    check("writes_outstanding", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic load_test1();
    stim = '{8'h03, 8'h00, 8'h11, 8'h00, 8'h22, 8'h01, 8'hFF, 8'h01};
  endtask

  task automatic build_random();
    int len;
    stim.delete();
    len = $urandom_range(0, 6);
    if ($urandom_range(0, 9) == 0) begin
      stim.push_back(8'($urandom));
      stim.push_back(8'($urandom_range(4, 255)));
    end else begin
      stim.push_back(8'(len));
      stim.push_back(8'h00);
      for (int i = 0; i < len; i++) begin
        stim.push_back(8'($urandom));
        stim.push_back(($urandom_range(0, 7) == 0) ? 8'($urandom_range(2, 255))
                                                   : 8'($urandom_range(0, 1)));
      end
    end
`ifdef LOADER_CHECKSUM_EN
    begin
      logic [7:0] x;
      x = xor_all();
      stim.push_back(($urandom_range(0, 3) == 0) ? (x ^ 8'($urandom_range(1, 255))) : x);
    end
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    #3;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_core_hold", 32'(core_hold), 32'd0);
    check("rst_load_done", 32'(load_done), 32'd0);
    check("rst_load_err", 32'(load_err), 32'd0);
    @(negedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Basic three-word load, then the same stream with random valid gaps.
    load_test1();
`ifdef LOADER_CHECKSUM_EN
    stim.push_back(xor_all());
`endif
    run_session(0);
    run_session(3);

    // Bad high byte in the only word: no write, error sticks, stream stalls.
    stim = '{8'h01, 8'h00, 8'h05, 8'h02};
    run_session(0);
    in_data  = 8'h11;
    in_valid = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("err_stalls_stream", 32'(in_ready), 32'd0);
    check("err_hold_kept", 32'(core_hold), 32'd1);
    in_valid = 1'b0;

    // Recovery, then empty program.
    load_test1();
`ifdef LOADER_CHECKSUM_EN
    stim.push_back(xor_all());
`endif
    run_session(1);
    stim = '{8'h00, 8'h00};
`ifdef LOADER_CHECKSUM_EN
    stim.push_back(8'h00);
`endif
    run_session(0);

    // Asynchronous reset while the first word's write is on the bus.
    start_pulse();
    send_byte(8'h03, 0);
    send_byte(8'h00, 0);
    send_byte(8'h11, 0);
    send_byte(8'h00, 0);
    check("hold_before_rst", 32'(core_hold), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check("mid_rst_wr_en", 32'(wr_en), 32'd0);
    check("mid_rst_wr_addr", 32'(wr_addr), 32'd0);
    check("mid_rst_wr_data", 32'(wr_data), 32'd0);
    check("mid_rst_core_hold", 32'(core_hold), 32'd0);
    check("mid_rst_load_done", 32'(load_done), 32'd0);
    check("mid_rst_load_err", 32'(load_err), 32'd0);
    @(negedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    load_test1();
`ifdef LOADER_CHECKSUM_EN
    stim.push_back(xor_all());
`endif
    run_session(2);

`ifdef LOADER_CHECKSUM_EN
    // Wrong trailer byte must be rejected.
    load_test1();
    stim.push_back(8'h00);
    run_session(0);
`endif

    // Length using the upper header bits (258 words).
    stim = '{8'h02, 8'h01};
    for (int i = 0; i < 258; i++) begin
      stim.push_back(8'($urandom));
      stim.push_back(8'($urandom_range(0, 1)));
    end
`ifdef LOADER_CHECKSUM_EN
    stim.push_back(xor_all());
`endif
    run_session(0);

    // Randomised sessions with occasional format errors.
    for (int s = 0; s < 14; s++) begin
      build_random();
      run_session($urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
